// File: rtl/sqrt_accel_p_if.sv
// Register-bus bundle for the square-root accelerator: chip-select/write access
// with combinational read data and a level interrupt.
interface sqrt_accel_p_if;
    logic        cs;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output cs, output we, output addr, output wdata,
                    input rdata, input irq);
    modport slave  (input cs, input we, input addr, input wdata,
                    output rdata, output irq);
endinterface

// File: rtl/sqrt_accel_p.sv
// Memory-mapped integer square root: a restoring digit-by-digit engine that
// retires two operand bits per cycle, with optional round-to-nearest on the root.
module sqrt_accel_p #(
    parameter int         WIDTH    = 32,
    parameter logic [1:0] RST_CTRL = 2'b00
) (
    input logic           clk,
    input logic           reset,
    sqrt_accel_p_if.slave bus
);
    localparam int H  = WIDTH / 2;
    localparam int CW = (H > 1) ? $clog2(H) : 1;
    localparam logic [CW-1:0] LAST = CW'(H - 1);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, next_state;

    logic [WIDTH-1:0] op_sr;
    logic [H:0]       rem_acc;
    logic [H-1:0]     root_acc;
    logic [CW-1:0]    cnt;
    logic             round_q;
    logic [H:0]       root_reg;
    logic [H:0]       rem_reg;
    logic             done;
    logic             err;
    logic [1:0]       ctrl;

    logic [3:0] off;
    logic       wr_op, wr_status, wr_ctrl, start, busy_wr, finish, busy;

    assign off = bus.addr[3:0];

    always_comb begin
        wr_op     = bus.cs && bus.we && (off == 4'h0);
        wr_status = bus.cs && bus.we && (off == 4'h4);
        wr_ctrl   = bus.cs && bus.we && (off == 4'hC);
        busy      = (state == BUSY);
        start     = wr_op && !busy;
        busy_wr   = wr_op && busy;
        finish    = busy && (cnt == LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)  next_state = BUSY;
            BUSY:    if (finish) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One restoring step: bring down the next operand pair and try subtracting 4*root+1.
    logic [H+2:0] shifted, trial, diff;
    logic         ge;
    logic [H:0]   rem_next;
    logic [H-1:0] root_next;
    logic [H:0]   root_floor, root_final;

    always_comb begin
        shifted    = {rem_acc, op_sr[WIDTH-1 -: 2]};
        trial      = {1'b0, root_acc, 2'b01};
        diff       = shifted - trial;
        ge         = (shifted >= trial);
        rem_next   = ge ? diff[H:0] : shifted[H:0];
        root_next  = {root_acc[H-2:0], ge};
        root_floor = {1'b0, root_next};
        root_final = (round_q && (rem_next > root_floor)) ? root_floor + 1'b1 : root_floor;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_sr    <= '0;
            rem_acc  <= '0;
            root_acc <= '0;
            cnt      <= '0;
            round_q  <= 1'b0;
            root_reg <= '0;
            rem_reg  <= '0;
        end else begin
            if (start) begin
                op_sr    <= bus.wdata[WIDTH-1:0];
                rem_acc  <= '0;
                root_acc <= '0;
                cnt      <= '0;
                round_q  <= ctrl[1];
            end else if (busy) begin
                op_sr    <= op_sr << 2;
                rem_acc  <= rem_next;
                root_acc <= root_next;
                cnt      <= cnt + CW'(1);
            end
            if (finish) begin
                root_reg <= root_final;
                rem_reg  <= rem_next;
            end
        end
    end

    // Setting a sticky flag takes priority over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
            err  <= 1'b0;
            ctrl <= RST_CTRL;
        end else begin
            if (finish)                         done <= 1'b1;
            else if (wr_status && bus.wdata[1]) done <= 1'b0;
            if (busy_wr)                        err  <= 1'b1;
            else if (wr_status && bus.wdata[2]) err  <= 1'b0;
            if (wr_ctrl)                        ctrl <= bus.wdata[1:0];
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.cs && !bus.we) begin
            case (off)
                4'h0:    bus.rdata = 32'(root_reg);
                4'h4:    bus.rdata = {29'b0, err, done, busy};
                4'h8:    bus.rdata = 32'(rem_reg);
                4'hC:    bus.rdata = {30'b0, ctrl};
                default: bus.rdata = '0;
            endcase
        end
    end

    assign bus.irq = done && ctrl[0];

endmodule

// File: doc/sqrt_accel_p.md
SQRT_ACCEL_P -- requirements
Module: sqrt_accel_p

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; even, 4..32.
REQ-002 SHALL have parameter RST_CTRL, default 2'b00: reset value of the control register.
REQ-003 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cs  input  1  chip select.
REQ-006 SHALL have port we  input  1  write enable; read when cs=1, we=0.
REQ-007 SHALL have port addr  input  32  byte address; only addr[3:0] decoded.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  combinational read data; 0 when cs=0, we=1, or offset unmapped.
REQ-010 SHALL have port irq  output  1  level interrupt = done & ctrl.irq_en.

Function
REQ-011 SHALL map offset 0x0: write = operand (wdata[WIDTH-1:0], upper bits ignored) plus start; read = ROOT, zero-extended.
REQ-012 SHALL map offset 0x4: read STATUS {29'b0, err, done, busy}; write-1-to-clear on wdata[1] (done) and wdata[2] (err).
REQ-013 SHALL map offset 0x8: read-only REM, the unrounded remainder operand - floor_root^2, zero-extended.
REQ-014 SHALL map offset 0xC: read/write CTRL {30'b0, round_en, irq_en}.
REQ-015 SHALL have two states, IDLE and BUSY; busy = (state==BUSY).
REQ-016 IDLE->BUSY SHALL occur on the edge sampling a 0x0 write; the operand SHALL be loaded into the core on that same edge, with no extra start-pulse cycle.
REQ-017 BUSY SHALL last exactly WIDTH/2 cycles, one restoring-sqrt digit (2 operand bits) per cycle.
REQ-018 On the edge ending the last iteration, the block SHALL:
  - load ROOT and REM;
  - return to IDLE;
  - set done.
REQ-019 ROOT SHALL be WIDTH/2+1 bits wide.
  - round_en=0: ROOT = floor(sqrt(operand)).
  - round_en=1: ROOT = floor_root + 1 if REM > floor_root, else floor_root.
REQ-020 REM SHALL be WIDTH/2+1 bits wide.
REQ-021 round_en SHALL be sampled at start, so a CTRL write during BUSY does not affect the current operation.
REQ-022 A 0x0 write during BUSY SHALL be ignored: operand, computation and ROOT are unaffected, and err is set (sticky).
REQ-023 ROOT and REM SHALL hold their previous values until the next completion, including while BUSY.
REQ-024 A new start SHALL NOT clear done; done is cleared only by W1C or reset.
REQ-025 If done-set or err-set coincides with a W1C of the same bit, set SHALL win.
REQ-026 A 0x0 write in the same cycle as completion (state still BUSY) SHALL be treated as busy-write (REQ-022); a 0x0 write on the following cycle SHALL start.
REQ-027 Operand 0 SHALL still take WIDTH/2 cycles and yield ROOT=0, REM=0.
REQ-028 Reads SHALL have no side effects.

Reset
REQ-029 On reset (async assert), the block SHALL:
  - go to state IDLE;
  - clear busy, done, err, ROOT, REM, internal accumulators and counter;
  - set CTRL to RST_CTRL;
  - drive irq=0.
REQ-030 Reset asserted mid-operation SHALL abort the computation, with no done and no result update.
REQ-031 After reset deasserts, the first 0x0 write SHALL start normally.

Verification (WIDTH=32, round_en=0 unless stated)
REQ-032 Write 0x0000_0010 -> busy high exactly 16 cycles, then ROOT=4, REM=0, STATUS=0x2.
REQ-033 Write 0xFFFF_FFFF -> ROOT=0x0000_FFFF, REM=0x0001_FFFE; repeat with round_en=1 -> ROOT=0x0001_0000, REM=0x0001_FFFE.
REQ-034 Rounding cases with round_en=1:
  - write 8 -> ROOT=3, REM=4;
  - write 10 -> ROOT=3, REM=1.
REQ-035 Busy-write: write 100, then write 49 two cycles later -> ROOT=10, STATUS=0x6; then write 0x6 to 0x4 -> STATUS=0x0.
REQ-036 IRQ with irq_en=1: write 0 -> after 16 cycles ROOT=0 and irq=1; W1C done -> irq=0.
REQ-037 Reset after 5 BUSY cycles of operand 81 -> STATUS=0, ROOT=0, irq=0; then write 81 -> ROOT=9 after 16 cycles.
REQ-038 The bench SHALL repeat REQ-032 and REQ-033 at WIDTH=8 (0xFF -> ROOT=15, REM=30; busy for 4 cycles).
